// File: rtl/bus_arbiter_4x1.sv
// Round-robin arbiter for the shared 8-bit 4:1 operand mux: one-hot grant, registered
// select, and a bounded tenure (MAX_HOLD) that a waiting requester can break unless lock is set.
module bus_arbiter_4x1 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] req,
  input  logic       lock,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       bus_valid,
  output logic [7:0] hold_cnt,
  output logic       state_dbg
);

  // Handshake: req[i] is a level; the requester keeps it high until gnt[i] is seen.
  // A grant lasts while req[i] stays high, bounded by MAX_HOLD when others wait and lock=0.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] ptr_q, ptr_d;
  logic       valid_q;

  logic [3:0] owner_oh;
  logic [3:0] others;
  logic [1:0] next_ptr;
  logic [2:0] idle_pick;
  logic [2:0] rel_pick;
  logic [2:0] pre_pick;

  // Returns {found, index} of the first set bit of r scanning start, start+1, ... (mod 4).
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = start + 2'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign owner_oh  = 4'b0001 << sel_q;
  assign others    = req & ~owner_oh;
  assign next_ptr  = sel_q + 2'd1;
  assign idle_pick = pick(req, ptr_q);
  assign rel_pick  = pick(req, next_ptr);
  assign pre_pick  = pick(others, next_ptr);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d  = 4'b0000;
        hold_d = 8'd0;
        if (idle_pick[2]) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << idle_pick[1:0];
          sel_d   = idle_pick[1:0];
          hold_d  = 8'd1;
        end
      end
      ST_GRANT: begin
        if (!req[sel_q]) begin
          // Release wins over preemption; both leave the pointer just past the owner.
          ptr_d = next_ptr;
          if (rel_pick[2]) begin
            gnt_d  = 4'b0001 << rel_pick[1:0];
            sel_d  = rel_pick[1:0];
            hold_d = 8'd1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            hold_d  = 8'd0;
          end
        end else if ((hold_q == MAX_CNT) && !lock && (others != 4'b0000)) begin
          ptr_d  = next_ptr;
          gnt_d  = 4'b0001 << pre_pick[1:0];
          sel_d  = pre_pick[1:0];
          hold_d = 8'd1;
        end else if (hold_q != MAX_CNT) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      hold_q  <= 8'd0;
      ptr_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      valid_q <= (state_d == ST_GRANT);
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign bus_valid = valid_q;
  assign hold_cnt  = hold_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_arbiter_4x1.sv
// Bench for bus_arbiter_4x1: directed scenarios then random traffic, checked
// against an integer-level round-robin model of owner, pointer and tenure count.
module tb_bus_arbiter_4x1;

  localparam int MAXH = 4;

  logic       CLK;
  logic       RESET;
  logic [3:0] req;
  logic       lock;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_valid;
  logic [7:0] hold_cnt;
  logic       state_dbg;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 when idle), pointer, tenure length, last select.
  int m_owner;
  int m_ptr;
  int m_hold;
  int m_sel;

  bus_arbiter_4x1 #(.MAX_HOLD(MAXH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req       (req),
    .lock      (lock),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .hold_cnt  (hold_cnt),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int winner(input logic [3:0] mask, input int start);
    for (int k = 0; k < 4; k++)
      if (mask[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_sel   = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic lk);
    int w;
    logic [3:0] rest;
    if (m_owner < 0) begin
      w = winner(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_hold  = 1;
      end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      w = winner(r, m_ptr);
      m_owner = w;
      m_hold  = (w >= 0) ? 1 : 0;
    end else begin
      rest = r;
      rest[m_owner] = 1'b0;
      if (m_hold == MAXH && !lk && rest != 4'b0000) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = winner(rest, m_ptr);
        m_hold  = 1;
      end else if (m_hold < MAXH) begin
        m_hold = m_hold + 1;
      end
    end
    if (m_owner >= 0) m_sel = m_owner;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check({tag, ".gnt"},   {4'b0, gnt},        {4'b0, eg});
    check({tag, ".sel"},   {6'b0, sel},        8'(m_sel));
    check({tag, ".valid"}, {7'b0, bus_valid},  {7'b0, (m_owner >= 0)});
    check({tag, ".hold"},  hold_cnt,           8'(m_hold));
    check({tag, ".state"}, {7'b0, state_dbg},  {7'b0, (m_owner >= 0)});
  endtask

  // Driver: apply inputs at the falling edge, let the model see the same
  // values at the rising edge, then sample 1 time unit later.
  task automatic step(input logic [3:0] r, input logic lk, input string tag);
    @(negedge CLK);
    req  = r;
    lock = lk;
    @(posedge CLK);
    model_edge(r, lk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    req   = 4'b0000;
    lock  = 1'b0;
    RESET = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    RESET = 1'b0;
    req   = 4'b0000;
    lock  = 1'b0;
    model_reset();
    #1;
    check_all("por");

    // Idle after reset
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, "idle");

    // Single requester from reset, release, then pointer lands on 3
    do_reset();
    step(4'b0100, 1'b0, "single");
    check("single.gnt_const", {4'b0, gnt}, 8'h04);
    check("single.sel_const", {6'b0, sel}, 8'h02);
    step(4'b0100, 1'b0, "single_hold");
    step(4'b0100, 1'b0, "single_hold");
    step(4'b0000, 1'b0, "single_rel");
    step(4'b1111, 1'b0, "ptr3");
    check("ptr3.gnt_const", {4'b0, gnt}, 8'h08);

    // Full round robin with all requesting
    do_reset();
    for (int i = 0; i < 22; i++) step(4'b1111, 1'b0, "rr");

    // Lock holds the owner past the limit; unlocking preempts at once
    do_reset();
    for (int i = 0; i < 10; i++) step(4'b0011, 1'b1, "lock");
    check("lock.hold_sat", hold_cnt, 8'd4);
    step(4'b0011, 1'b0, "unlock");
    check("unlock.gnt_const", {4'b0, gnt}, 8'h02);
    check("unlock.hold_const", hold_cnt, 8'd1);

    // Owner 1 releases with 3 and 0 waiting: zero-bubble handover to 3
    do_reset();
    step(4'b0010, 1'b0, "own1");
    step(4'b0010, 1'b0, "own1");
    step(4'b1001, 1'b0, "handover");
    check("handover.gnt_const", {4'b0, gnt}, 8'h08);
    check("handover.sel_const", {6'b0, sel}, 8'h03);

    // Asynchronous reset between edges, mid-tenure
    step(4'b1001, 1'b0, "pre_async");
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(negedge CLK);
    req   = 4'b0010;
    RESET = 1'b1;
    @(posedge CLK);
    model_edge(4'b0010, 1'b0);
    #1;
    check_all("after_async");
    check("after_async.gnt_const", {4'b0, gnt}, 8'h02);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 150 == 149) do_reset();
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_4x1.md
Name: bus_arbiter_4x1

Overview:
- Round-robin arbiter and sequencer for the shared 8-bit 4:1 operand/bus mux.
- Grants one of four requesters at a time. Drives the mux select and a one-hot grant. Bounds each tenure to MAX_HOLD cycles when others are waiting.
- Sits between requesting units (register file ports, ALU result, memory read, immediate path) and the mux select input.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant while another requester waits; legal range 1..255.

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset (asserted when 0)
- req  input  4  request per source; req[i] corresponds to mux input in<i>
- lock  input  1  when 1, the current owner is not preempted by the hold limit
- gnt  output  4  one-hot grant, registered; all-zero when idle
- sel  output  2  mux select, registered; encodes the index of the set gnt bit
- bus_valid  output  1  registered; 1 whenever gnt != 0
- hold_cnt  output  8  registered count of cycles the current owner has held the grant

Behaviour:
- Reset (RESET=0, any time, asynchronous): state=IDLE, gnt=0000, sel=00, bus_valid=0, hold_cnt=0, priority pointer ptr=0. Takes effect immediately, including mid-tenure. Exit is on the first rising edge with RESET=1.
- Search order: starting at ptr, check ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first index with an eligible request wins.
- IDLE state:
  - If req != 0 at an edge: grant the winner at that edge, go to GRANT.
  - Set gnt=onehot(w), sel=w, bus_valid=1, hold_cnt=1.
  - Latency: req sampled high at edge n -> gnt visible after edge n.
  - If req == 0: stay IDLE; sel holds its last value; gnt=0, bus_valid=0.
- GRANT state, owner o, evaluated at each edge in priority order:
  - Release: req[o]=0. Set ptr=o+1 mod 4. Search among req (req[o] is already 0). If a winner exists, grant it at this same edge (zero-bubble handover, hold_cnt=1). Otherwise go to IDLE with gnt=0.
  - Preempt: req[o]=1, hold_cnt==MAX_HOLD, lock=0, and (req & ~onehot(o)) != 0. Set ptr=o+1 mod 4. Grant the winner among req with bit o masked; hold_cnt=1.
  - Continue: otherwise keep o. hold_cnt increments and saturates at MAX_HOLD, never wrapping. Preemption triggers on the first edge another request appears after saturation (if lock=0).
- lock:
  - Only suppresses preemption; release by the owner still takes effect.
  - lock has no effect in IDLE.
  - Deasserting lock while hold_cnt is saturated and others wait preempts at that next edge.
- Simultaneous events:
  - Owner drops req in the same cycle as saturation: treated as release, not preemption. The resulting ptr is identical.
  - Multiple new requesters: resolved strictly by ptr order.
- Invariants:
  - gnt is always zero or one-hot.
  - sel == index(gnt) whenever bus_valid=1.
  - A continuously requesting source waits at most 3*MAX_HOLD cycles once all others saturate.
- Timing note: the mux output settles one time unit after sel changes. Consumers sample mux data on the edge after the grant edge.
- Requests are level-sensitive. A requester must hold req until it sees its gnt bit; dropping earlier forfeits the slot with no error.

Test Plan:
- Reset then req=0000 for 5 cycles -> gnt=0000, bus_valid=0, sel=00, hold_cnt=0 throughout.
- From reset, req=0100 at edge 1 -> after edge 1: gnt=0100, sel=10, bus_valid=1, hold_cnt=1. req drops at edge 4 -> gnt=0000 after edge 4, ptr=3.
- MAX_HOLD=4, req=1111 held -> owners 0,1,2,3,0 each for exactly 4 cycles; sel sequence 00,01,10,11,00; no idle cycle between tenures.
- MAX_HOLD=4, req=0011, lock=1 for 10 cycles -> source 0 holds all 10 cycles, hold_cnt saturates at 4. lock->0 -> next edge gnt=0010, hold_cnt=1.
- Owner 1 with hold_cnt=2 drops req while req[3]=1 and req[0]=1 -> same edge gnt=1000 (ptr=2, searching 2,3,0,1), sel=11.
- Assert RESET=0 mid-tenure between clock edges -> gnt, sel, bus_valid, hold_cnt go to 0 immediately without an edge. After release with req=0010 -> first edge grants 0010.
